lfsr_arbiter: RTL and testbench

LFSR_ARBITER -- requirements
Module: lfsr_arbiter

---
 rtl/lfsr_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_lfsr_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_arbiter.sv
// lfsr_arbiter: round-robin arbiter that serves each granted requester one
// WORD_W-bit random word drawn from a 16-bit Fibonacci LFSR.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - asynchronous, active-low reset
//   req        - per-requester request for one random word
//   ack        - granted requester accepts rnd_data (honoured only in HOLD)
//   seed_load  - load seed_in into the LFSR (honoured only in IDLE)
//   seed_in    - new seed; 16'hFFFF (lock-up value) is replaced by 16'hB4F3
//   gnt        - registered one-hot grant
//   rnd_valid  - rnd_data complete and stable
//   rnd_data   - delivered random word
//   busy       - FSM is not in IDLE
//   max_tick   - combinational: LFSR state equals the active seed
//   num_ones   - (LFSR_STATS_EN only) saturating count of 1 bits shifted out
//   num_zeroes - (LFSR_STATS_EN only) saturating count of 0 bits shifted out
//
// Build option: define LFSR_STATS_EN to add the num_ones/num_zeroes counters.
module lfsr_arbiter #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned WORD_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_REQ-1:0]  req,
  input  logic              ack,
  input  logic              seed_load,
  input  logic [15:0]       seed_in,
  output logic [N_REQ-1:0]  gnt,
  output logic              rnd_valid,
  output logic [WORD_W-1:0] rnd_data,
  output logic              busy,
  output logic              max_tick
`ifdef LFSR_STATS_EN
  ,
  output logic [15:0]       num_ones,
  output logic [15:0]       num_zeroes
`endif
);

  localparam int unsigned LFSR_W     = 16;
  localparam int unsigned IDX_W      = $clog2(N_REQ);
  localparam int unsigned CNT_W      = 5;
  localparam logic [LFSR_W-1:0] RESET_SEED = 16'hB4F3;
  localparam logic [LFSR_W-1:0] LOCKUP     = 16'hFFFF;
  localparam logic [CNT_W-1:0]  LAST_BIT   = CNT_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic               valid_q, valid_d;
  logic [LFSR_W-1:0]  data_q, data_d;
  logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
  logic [LFSR_W-1:0]  seed_q, seed_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;

  logic [LFSR_W-1:0]  lfsr_nxt;
  logic [LFSR_W-1:0]  seed_fix;
  logic               req_held;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand;

  // Four-tap XNOR feedback; the all-ones state is the lock-up value.
  assign lfsr_nxt = {lfsr_q[LFSR_W-2:0],
                     ~(lfsr_q[3] ^ lfsr_q[12] ^ lfsr_q[14] ^ lfsr_q[15])};

  // Never let a seed park the LFSR in its lock-up state.
  assign seed_fix = (seed_in == LOCKUP) ? RESET_SEED : seed_in;

  // The current winner still wants its word.
  assign req_held = |(req & gnt_q);

  // Round-robin search starting at the index after the last winner.
  always_comb begin : p_rr
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = IDX_W'((32'(ptr_q) + i) % N_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin : p_next
    state_d = state_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    data_d  = data_q;
    lfsr_d  = lfsr_q;
    seed_d  = seed_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (seed_load) begin
          lfsr_d = seed_fix;
          seed_d = seed_fix;
        end else if (win_found) begin
          gnt_d   = N_REQ'(1) << win_idx;
          gidx_d  = win_idx;
          data_d  = '0;
          cnt_d   = '0;
          state_d = GEN;
        end
      end

      GEN: begin
        if (!req_held) begin
          // Abort: the LFSR keeps its state so the next word continues the sequence.
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = gidx_q;
        end else begin
          lfsr_d = lfsr_nxt;
          data_d = {data_q[LFSR_W-2:0], lfsr_q[15]};
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            state_d = HOLD;
            valid_d = 1'b1;
          end
        end
      end

      HOLD: begin
        if (!req_held || ack) begin
          state_d = IDLE;
          gnt_d   = '0;
          valid_d = 1'b0;
          ptr_d   = gidx_q;
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin : p_regs
    if (!reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      lfsr_q  <= RESET_SEED;
      seed_q  <= RESET_SEED;
      ptr_q   <= IDX_W'(N_REQ - 1);
      gidx_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      lfsr_q  <= lfsr_d;
      seed_q  <= seed_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt       = gnt_q;
  assign rnd_valid = valid_q;
  assign rnd_data  = data_q[WORD_W-1:0];
  assign busy      = busy_q;
  assign max_tick  = (lfsr_q == seed_q);

`ifdef LFSR_STATS_EN
  logic stat_inc;
  logic stat_clr;

  assign stat_inc = (state_q == GEN) && req_held;
  assign stat_clr = (state_q == IDLE) && seed_load;

  // Saturating bit-population counters over every bit shifted into rnd_data.
  always_ff @(posedge clk or negedge reset) begin : p_stats
    if (!reset) begin
      num_ones   <= '0;
      num_zeroes <= '0;
    end else if (stat_clr) begin
      num_ones   <= '0;
      num_zeroes <= '0;
    end else if (stat_inc) begin
      if (lfsr_q[15]) begin
        if (num_ones != 16'hFFFF) num_ones <= num_ones + 16'd1;
      end else begin
        if (num_zeroes != 16'hFFFF) num_zeroes <= num_zeroes + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_arbiter.sv
// Testbench for lfsr_arbiter: table-driven transactions with a scoreboard of
// expected {grant index, word}, plus hand-written abort and reset sequences.
module tb_lfsr_arbiter;

  localparam int unsigned N_REQ  = 4;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned N_VEC  = 9;

  typedef struct {
    logic [3:0]  req;
    bit          seed_ld;
    logic [15:0] seed;
    bit          poke;
    int          idx;
    logic [15:0] word;
  } vec_t;

  typedef struct {
    int          idx;
    logic [15:0] word;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic        ack;
  logic        seed_load;
  logic [15:0] seed_in;
  logic [3:0]  gnt;
  logic        rnd_valid;
  logic [15:0] rnd_data;
  logic        busy;
  logic        max_tick;
`ifdef LFSR_STATS_EN
  logic [15:0] num_ones;
  logic [15:0] num_zeroes;
`endif

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  vec_t tbl[N_VEC];

  lfsr_arbiter #(.N_REQ(N_REQ), .WORD_W(WORD_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .ack       (ack),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .gnt       (gnt),
    .rnd_valid (rnd_valid),
    .rnd_data  (rnd_data),
    .busy      (busy),
    .max_tick  (max_tick)
`ifdef LFSR_STATS_EN
    ,
    .num_ones  (num_ones),
    .num_zeroes(num_zeroes)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] adv(input logic [15:0] s, input int n);
    logic [15:0] x;
    x = s;
    for (int i = 0; i < n; i++) x = {x[14:0], ~(x[3] ^ x[12] ^ x[14] ^ x[15])};
    return x;
  endfunction

  function automatic logic [3:0] oh(input int i);
    logic [3:0] one;
    one = 4'b0001;
    return one << i;
  endfunction

  // One request/word transaction; called and returns at a falling edge.
  task automatic txn(input logic [3:0] r, input int exp_idx, input logic [15:0] exp_word,
                     input bit poke, input bit chk_tick, input bit rst_hold);
    exp_t e;
    bit   got_valid;
    int   oh_err;
    e.idx  = exp_idx;
    e.word = exp_word;
    sb.push_back(e);
    req       = r;
    got_valid = 1'b0;
    oh_err    = 0;
    for (int cyc = 1; cyc <= 40 && !got_valid; cyc++) begin
      @(negedge clk);
      if (poke && cyc == 3) begin
        ack = 1'b1; seed_load = 1'b1; seed_in = 16'h1234;
      end else begin
        ack = 1'b0; seed_load = 1'b0;
      end
      if ($countones(gnt) != 1) oh_err++;
      if (cyc == 1) begin
        chk("gnt_latency", 32'(gnt), 32'(oh(exp_idx)));
        chk("busy_gen", 32'(busy), 1);
        if (chk_tick) chk("tick_first", 32'(max_tick), 1);
      end
      if (cyc == 2 && chk_tick) chk("tick_gen", 32'(max_tick), 0);
      if (rnd_valid) begin
        got_valid = 1'b1;
        chk("valid_latency", 32'(cyc), 32'(WORD_W + 1));
        e = sb.pop_front();
        chk("word", 32'(rnd_data), 32'(e.word));
        chk("gnt_at_valid", 32'(gnt), 32'(oh(e.idx)));
      end
    end
    chk("valid_timeout", 32'(got_valid), 1);
    chk("gnt_onehot_errs", 32'(oh_err), 0);
    if (!got_valid && sb.size() > 0) void'(sb.pop_front());
    ack = 1'b0; seed_load = 1'b0;
    @(negedge clk);
    chk("hold_valid", 32'(rnd_valid), 1);
    chk("hold_data", 32'(rnd_data), 32'(exp_word));
    chk("hold_gnt", 32'(gnt), 32'(oh(exp_idx)));
    if (rst_hold) begin
      #2 reset = 1'b0;
      #1;
      chk("arst_gnt", 32'(gnt), 0);
      chk("arst_valid", 32'(rnd_valid), 0);
      chk("arst_busy", 32'(busy), 0);
`ifdef LFSR_STATS_EN
      chk("arst_ones", 32'(num_ones), 0);
`endif
      @(negedge clk);
      reset = 1'b1;
      req   = '0;
    end else begin
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      chk("bubble_gnt", 32'(gnt), 0);
      chk("bubble_valid", 32'(rnd_valid), 0);
      chk("bubble_busy", 32'(busy), 0);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [15:0] w;
    logic [15:0] lm;
    bit          seen_valid;

    reset = 1'b0; req = '0; ack = 1'b0; seed_load = 1'b0; seed_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_valid", 32'(rnd_valid), 0);
    chk("rst_data", 32'(rnd_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tick", 32'(max_tick), 1);
    reset = 1'b1;
    @(negedge clk);

    // First word after reset is the reset seed itself, granted to index 0.
    txn(4'b0001, 0, 16'hB4F3, 1'b0, 1'b1, 1'b0);
`ifdef LFSR_STATS_EN
    chk("stats_ones", 32'(num_ones), 10);
    chk("stats_zeroes", 32'(num_zeroes), 6);
`endif

    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    req   = '0;
    @(negedge clk);

    w = 16'hB4F3;
    tbl[0] = '{4'b1111, 1'b0, 16'h0000, 1'b0, 0, w}; w = adv(w, 16);
    tbl[1] = '{4'b1111, 1'b0, 16'h0000, 1'b0, 1, w}; w = adv(w, 16);
    tbl[2] = '{4'b1111, 1'b0, 16'h0000, 1'b1, 2, w}; w = adv(w, 16);
    tbl[3] = '{4'b1111, 1'b0, 16'h0000, 1'b0, 3, w}; w = adv(w, 16);
    tbl[4] = '{4'b1111, 1'b0, 16'h0000, 1'b0, 0, w};
    tbl[5] = '{4'b0100, 1'b1, 16'hFFFF, 1'b0, 2, 16'hB4F3};
    tbl[6] = '{4'b0100, 1'b1, 16'h0001, 1'b0, 2, 16'h0001};
    w = adv(16'h0001, 16);
    tbl[7] = '{4'b1010, 1'b0, 16'h0000, 1'b0, 3, w}; w = adv(w, 16);
    tbl[8] = '{4'b0011, 1'b0, 16'h0000, 1'b0, 0, w};
    lm = adv(w, 16);

    for (int i = 0; i < N_VEC; i++) begin
      if (tbl[i].seed_ld) begin
        seed_load = 1'b1;
        seed_in   = tbl[i].seed;
        req       = tbl[i].req;
        @(negedge clk);
        seed_load = 1'b0;
        chk("seed_prio_gnt", 32'(gnt), 0);
        chk("seed_tick", 32'(max_tick), 1);
`ifdef LFSR_STATS_EN
        chk("seed_clr_ones", 32'(num_ones), 0);
        chk("seed_clr_zeroes", 32'(num_zeroes), 0);
`endif
      end
      txn(tbl[i].req, tbl[i].idx, tbl[i].word, tbl[i].poke, tbl[i].seed_ld, 1'b0);
    end

    // Abort in GEN: four advances happen before req[1] drops.
    req        = 4'b0010;
    seen_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (rnd_valid) seen_valid = 1'b1;
      if (k == 1) chk("abort_gnt", 32'(gnt), 32'(4'b0010));
    end
    req = '0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_gnt_clr", 32'(gnt), 0);
    chk("abort_no_valid", 32'(seen_valid | rnd_valid), 0);
    lm = adv(lm, 4);
    txn(4'b0010, 1, lm, 1'b0, 1'b0, 1'b0);
    lm = adv(lm, 16);

    // Reset in HOLD discards the word; the sequence restarts from the reset seed.
    txn(4'b0001, 0, lm, 1'b0, 1'b0, 1'b1);
    txn(4'b0001, 0, 16'hB4F3, 1'b0, 1'b1, 1'b0);

    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
